t5_dwbm: RTL and testbench

Data-bus initiator for the t5 pipeline. It accepts load/store requests from the execute stage and computes byte-lane select and store-data steering. It runs one Wishbone classic cycle per request on the data port and stalls the pipeline until the responder acknowledges. It generates `xsel`, the registered lane select that the write-back stage uses to extract and extend load data returned on `dwb_dti`.

---
 rtl/t5_pkg.sv | 20 ++
 rtl/t5_dwbm_if.sv | 22 ++
 rtl/t5_lane.sv | 38 +++
 rtl/t5_dwbm.sv | 103 ++++++++++
 tb/tb_t5_dwbm.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/t5_pkg.sv
// Shared encodings for the t5 data-bus initiator: access size, FSM states and lane selects.
package t5_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [3:0] SEL_B  = 4'h1;
    localparam logic [3:0] SEL_HL = 4'h3;
    localparam logic [3:0] SEL_HH = 4'hC;
    localparam logic [3:0] SEL_W  = 4'hF;

endpackage

// File: rtl/t5_dwbm_if.sv
// Wishbone classic data-port signals between the t5 initiator and a responder.
interface t5_dwbm_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] dwb_adr;
    logic [XLEN-1:0] dwb_dto;
    logic [3:0]      dwb_sel;
    logic            dwb_stb;
    logic            dwb_cyc;
    logic            dwb_wre;
    logic            dwb_ack;

    modport master (
        output dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_cyc, dwb_wre,
        input  dwb_ack
    );

    modport slave (
        input  dwb_adr, dwb_dto, dwb_sel, dwb_stb, dwb_cyc, dwb_wre,
        output dwb_ack
    );
endinterface

// File: rtl/t5_lane.sv
// Byte-lane select, store-data steering and misalignment detection for one access.
module t5_lane
    import t5_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      sz,
    input  logic [1:0]      adr,
    input  logic [XLEN-1:0] dat,
    output logic [3:0]      sel_c,
    output logic [XLEN-1:0] dto_c,
    output logic            mis_c
);

    // Size code 11 has no defined access width and is always rejected.
    always_comb begin
        sel_c = 4'h0;
        dto_c = dat;
        mis_c = 1'b0;
        case (sz)
            SZ_B: begin
                sel_c = SEL_B << adr;
                dto_c = {(XLEN/8){dat[7:0]}};
            end
            SZ_H: begin
                sel_c = adr[1] ? SEL_HH : SEL_HL;
                dto_c = {(XLEN/16){dat[15:0]}};
                mis_c = adr[0];
            end
            SZ_W: begin
                sel_c = SEL_W;
                mis_c = (adr != 2'b00);
            end
            default: mis_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/t5_dwbm.sv
// t5 data-bus initiator: one Wishbone classic cycle per load/store, pipeline stall
// until ack, bus timeout and misalignment reporting.
module t5_dwbm
    import t5_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TMO  = 8
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             sena,
    input  logic             xreq,
    input  logic             xwre,
    input  logic [14:12]     xfn3,
    input  logic [XLEN-1:0]  xadr,
    input  logic [XLEN-1:0]  xdat,
    t5_dwbm_if.master        dwb,
    output logic [3:0]       xsel,
    output logic             dstall,
    output logic             dmis,
    output logic             derr
);

    state_e          state_q;
    state_e          state_d;
    logic [TMO-1:0]  tmo_q;
    logic            acc_c;
    logic            load_c;
    logic            timeout_c;
    logic [3:0]      sel_c;
    logic [XLEN-1:0] dto_c;
    logic            mis_c;
    logic            unused_fn3;

    assign unused_fn3 = xfn3[14];

    t5_lane #(.XLEN(XLEN)) u_lane (
        .sz    (xfn3[13:12]),
        .adr   (xadr[1:0]),
        .dat   (xdat),
        .sel_c (sel_c),
        .dto_c (dto_c),
        .mis_c (mis_c)
    );

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // An ack in WAIT frees the bus for a new access on the same edge.
    always_comb begin
        state_d   = state_q;
        acc_c     = sena & xreq & ((state_q == IDLE) | ((state_q == WAIT) & dwb.dwb_ack));
        load_c    = acc_c & ~mis_c;
        timeout_c = (state_q == WAIT) & ~dwb.dwb_ack & (tmo_q == '1);
        dstall    = (state_q == WAIT) & ~dwb.dwb_ack & ~timeout_c;
        case (state_q)
            IDLE: begin
                if (load_c) state_d = WAIT;
            end
            WAIT: begin
                if (dwb.dwb_ack)    state_d = load_c ? WAIT : IDLE;
                else if (timeout_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            dwb.dwb_adr <= '0;
            dwb.dwb_dto <= '0;
            dwb.dwb_sel <= 4'h0;
            dwb.dwb_stb <= 1'b0;
            dwb.dwb_cyc <= 1'b0;
            dwb.dwb_wre <= 1'b0;
            xsel        <= 4'h0;
            dmis        <= 1'b0;
            derr        <= 1'b0;
        end else begin
            dwb.dwb_stb <= (state_d == WAIT);
            dwb.dwb_cyc <= (state_d == WAIT);
            dmis        <= acc_c & mis_c;
            derr        <= timeout_c;
            if (load_c) begin
                dwb.dwb_adr <= {xadr[XLEN-1:2], 2'b00};
                dwb.dwb_dto <= dto_c;
                dwb.dwb_sel <= sel_c;
                dwb.dwb_wre <= xwre;
                xsel        <= sel_c;
            end
        end
    end

    // Counts unacknowledged WAIT cycles; cleared by every accept.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst)                                     tmo_q <= '0;
        else if (acc_c)                               tmo_q <= '0;
        else if ((state_q == WAIT) & ~dwb.dwb_ack)    tmo_q <= tmo_q + TMO'(1);
    end

endmodule

// File: tb/tb_t5_dwbm.sv
// Scoreboard bench for t5_dwbm: directed accesses push expected bus cycles and
// dmis/derr events; a negedge monitor pops and compares them.
module tb_t5_dwbm;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dto;
        logic [3:0]  sel;
        logic        wre;
    } bus_t;

    localparam int EV_MIS = 1;
    localparam int EV_ERR = 2;

    logic        sclk;
    logic        srst;
    logic        sena;
    logic        xreq;
    logic        xwre;
    logic [14:12] xfn3;
    logic [31:0] xadr;
    logic [31:0] xdat;
    logic [3:0]  xsel;
    logic        dstall;
    logic        dmis;
    logic        derr;

    int n_chk  = 0;
    int n_pass = 0;

    bus_t bus_q[$];
    int   ev_q[$];

    t5_dwbm_if #(.XLEN(32)) dwb ();

    t5_dwbm #(.XLEN(32), .TMO(8)) dut (
        .sclk   (sclk),
        .srst   (srst),
        .sena   (sena),
        .xreq   (xreq),
        .xwre   (xwre),
        .xfn3   (xfn3),
        .xadr   (xadr),
        .xdat   (xdat),
        .dwb    (dwb),
        .xsel   (xsel),
        .dstall (dstall),
        .dmis   (dmis),
        .derr   (derr)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic drive(input logic wre, input logic [2:0] fn3, input logic [31:0] adr,
                         input logic [31:0] dat);
        xreq = 1'b1;
        xwre = wre;
        xfn3 = fn3;
        xadr = adr;
        xdat = dat;
    endtask

    task automatic push_bus(input logic [31:0] adr, input logic [31:0] dto,
                            input logic [3:0] sel, input logic wre);
        bus_t e;
        e.adr = adr;
        e.dto = dto;
        e.sel = sel;
        e.wre = wre;
        bus_q.push_back(e);
    endtask

    // One access acked in its first strobe cycle.
    task automatic run_vec(input logic wre, input logic [2:0] fn3, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] esel,
                           input logic [31:0] edto);
        drive(wre, fn3, adr, dat);
        push_bus({adr[31:2], 2'b00}, edto, esel, wre);
        tick();
        xreq = 1'b0;
        dwb.dwb_ack = 1'b1;
        #1;
        chk("vec_dstall_ack", 32'(dstall), 32'h0);
        tick();
        dwb.dwb_ack = 1'b0;
        chk("vec_xsel", 32'(xsel), 32'(esel));
        chk("vec_stb_drop", 32'(dwb.dwb_stb), 32'h0);
    endtask

    // Monitor: compare each completed bus cycle and each dmis/derr pulse.
    always @(negedge sclk) begin
        if (dwb.dwb_stb && dwb.dwb_cyc && dwb.dwb_ack) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", dwb.dwb_adr, 32'hFFFF_FFFF);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk("bus_adr", dwb.dwb_adr, e.adr);
                chk("bus_dto", dwb.dwb_dto, e.dto);
                chk("bus_sel", 32'(dwb.dwb_sel), 32'(e.sel));
                chk("bus_wre", 32'(dwb.dwb_wre), 32'(e.wre));
            end
        end
        if (dmis) begin
            if (ev_q.size() == 0) chk("dmis_unexpected", 32'h1, 32'h0);
            else chk("ev_dmis", 32'(EV_MIS), 32'(ev_q.pop_front()));
        end
        if (derr) begin
            if (ev_q.size() == 0) chk("derr_unexpected", 32'h1, 32'h0);
            else chk("ev_derr", 32'(EV_ERR), 32'(ev_q.pop_front()));
        end
        if (dmis && derr) chk("dmis_derr_together", 32'h1, 32'h0);
    end

    initial begin
        int n;
        srst = 1'b0;
        sena = 1'b1;
        xreq = 1'b0;
        xwre = 1'b0;
        xfn3 = 3'b000;
        xadr = '0;
        xdat = '0;
        dwb.dwb_ack = 1'b0;
        #2 srst = 1'b1;
        tick();
        tick();
        chk("rst_stb", 32'(dwb.dwb_stb), 32'h0);
        chk("rst_cyc", 32'(dwb.dwb_cyc), 32'h0);
        chk("rst_adr", dwb.dwb_adr, 32'h0);
        chk("rst_sel_xsel", {24'h0, dwb.dwb_sel, xsel}, 32'h0);
        chk("rst_flags", {28'h0, dstall, dmis, derr, dwb.dwb_wre}, 32'h0);
        srst = 1'b0;
        tick();

        // Ack while idle must be ignored.
        dwb.dwb_ack = 1'b1;
        tick();
        chk("idle_ack_stb", 32'(dwb.dwb_stb), 32'h0);
        chk("idle_ack_dstall", 32'(dstall), 32'h0);
        dwb.dwb_ack = 1'b0;
        tick();

        // Byte store, ack one cycle after strobe rises.
        drive(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        push_bus(32'h0000_1000, 32'hDDDD_DDDD, 4'h8, 1'b1);
        tick();
        xreq = 1'b0;
        chk("bst_stb", 32'(dwb.dwb_stb), 32'h1);
        chk("bst_dstall_wait", 32'(dstall), 32'h1);
        tick();
        dwb.dwb_ack = 1'b1;
        #1;
        chk("bst_dstall_ack", 32'(dstall), 32'h0);
        tick();
        dwb.dwb_ack = 1'b0;
        chk("bst_stb_drop", 32'(dwb.dwb_stb), 32'h0);
        chk("bst_xsel", 32'(xsel), 32'h8);

        // Half load, ack after three stalled cycles.
        drive(1'b0, 3'b001, 32'h0000_2002, 32'h1234_5678);
        push_bus(32'h0000_2000, 32'h5678_5678, 4'hC, 1'b0);
        tick();
        xreq = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            dwb.dwb_ack = (i == 3);
            #1;
            if (!dstall) break;
            n++;
            tick();
        end
        chk("hld_stall_cycles", 32'(n), 32'd3);
        tick();
        dwb.dwb_ack = 1'b0;
        chk("hld_xsel", 32'(xsel), 32'hC);
        chk("hld_cyc_drop", 32'(dwb.dwb_cyc), 32'h0);

        // Misaligned word: no cycle, one dmis pulse, xsel untouched.
        drive(1'b0, 3'b010, 32'h0000_1001, 32'h0);
        ev_q.push_back(EV_MIS);
        tick();
        xreq = 1'b0;
        chk("mis_stb", 32'(dwb.dwb_stb), 32'h0);
        chk("mis_dmis", 32'(dmis), 32'h1);
        tick();
        chk("mis_dmis_drop", 32'(dmis), 32'h0);
        chk("mis_xsel", 32'(xsel), 32'hC);
        drive(1'b1, 3'b011, 32'h0000_0000, 32'h0);
        ev_q.push_back(EV_MIS);
        tick();
        xreq = 1'b0;
        chk("mis11_stb", 32'(dwb.dwb_stb), 32'h0);
        tick();

        // Lane steering vectors.
        run_vec(1'b0, 3'b000, 32'h0000_0021, 32'h0000_00A5, 4'h2, 32'hA5A5_A5A5);
        run_vec(1'b1, 3'b001, 32'h0000_0030, 32'h0000_BEEF, 4'h3, 32'hBEEF_BEEF);
        run_vec(1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
        run_vec(1'b1, 3'b100, 32'h0000_0052, 32'h0000_007F, 4'h4, 32'h7F7F_7F7F);

        // Back-to-back: store acked while the next load is accepted.
        drive(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344);
        push_bus(32'h0000_0010, 32'h1122_3344, 4'hF, 1'b1);
        tick();
        drive(1'b0, 3'b010, 32'h0000_0014, 32'h5566_7788);
        push_bus(32'h0000_0014, 32'h5566_7788, 4'hF, 1'b0);
        dwb.dwb_ack = 1'b1;
        #1;
        chk("b2b_adr_first", dwb.dwb_adr, 32'h0000_0010);
        chk("b2b_dstall", 32'(dstall), 32'h0);
        tick();
        xreq = 1'b0;
        chk("b2b_stb_held", 32'(dwb.dwb_stb), 32'h1);
        chk("b2b_adr_second", dwb.dwb_adr, 32'h0000_0014);
        tick();
        dwb.dwb_ack = 1'b0;
        chk("b2b_stb_drop", 32'(dwb.dwb_stb), 32'h0);

        // Timeout: no ack, stall 2^8-1 cycles then derr.
        drive(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        ev_q.push_back(EV_ERR);
        tick();
        xreq = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (!dwb.dwb_stb) break;
            if (dstall) n++;
            tick();
        end
        chk("tmo_stall_cycles", 32'(n), 32'd255);
        chk("tmo_cyc", 32'(dwb.dwb_cyc), 32'h0);
        chk("tmo_derr", 32'(derr), 32'h1);
        tick();
        chk("tmo_derr_drop", 32'(derr), 32'h0);
        run_vec(1'b1, 3'b010, 32'h0000_0200, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D);

        // Reset asserted mid-cycle during WAIT.
        drive(1'b1, 3'b010, 32'h0000_0300, 32'h0F0F_0F0F);
        tick();
        xreq = 1'b0;
        chk("rmid_stb_before", 32'(dwb.dwb_stb), 32'h1);
        #2 srst = 1'b1;
        #1;
        chk("rmid_stb", 32'(dwb.dwb_stb), 32'h0);
        chk("rmid_cyc", 32'(dwb.dwb_cyc), 32'h0);
        chk("rmid_dstall", 32'(dstall), 32'h0);
        chk("rmid_adr", dwb.dwb_adr, 32'h0);
        chk("rmid_dto", dwb.dwb_dto, 32'h0);
        chk("rmid_sel_xsel", {24'h0, dwb.dwb_sel, xsel}, 32'h0);
        tick();
        srst = 1'b0;
        tick();
        tick();

        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        chk("ev_q_empty", 32'(ev_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
